// File: rtl/counter_pkg.sv
// counter_pkg: shared direction and mode encodings for the programmable up/down counter
package counter_pkg;
  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_ONESHOT = 1'b1} cnt_mode_t;
endpackage

// File: rtl/counter_terminal_detect.sv
// counter_terminal_detect: terminal value, end-of-count and out-of-range detection
module counter_terminal_detect
  import counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] command_length,
  input  cnt_dir_t     direction,
  output logic [W-1:0] terminal,
  output logic         at_end,
  output logic         above_terminal
);
  assign terminal       = command_length - W'(1);
  assign at_end         = count == (direction == CNT_UP ? terminal : '0);
  assign above_terminal = count > terminal;
endmodule

// File: rtl/programmable_updown_counter.sv
// programmable_updown_counter: length-programmable up/down counter with wrap/one-shot modes
module programmable_updown_counter
  import counter_pkg::*;
#(
  parameter int WORD_LENGTH      = 8,
  parameter bit ONE_SHOT_DEFAULT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sync_reset,
  input  logic                   load,
  input  logic [WORD_LENGTH-1:0] load_value,
  input  logic [WORD_LENGTH-1:0] command_length,
  input  logic                   up_down,
  input  logic                   mode_we,
  input  logic                   one_shot_in,
  output logic [WORD_LENGTH-1:0] count_out,
  output logic                   finish_count,
  output logic                   wrap_pulse,
  output logic                   done
);
  logic [WORD_LENGTH-1:0] terminal, count_next, restart;
  logic at_end, above_terminal, step, done_next, pulse_next;
  cnt_mode_t mode;
  cnt_dir_t dir;
  assign dir = up_down ? CNT_UP : CNT_DOWN;
  counter_terminal_detect #(.W(WORD_LENGTH)) u_detect (
    .count          (count_out),
    .command_length (command_length),
    .direction      (dir),
    .terminal       (terminal),
    .at_end         (at_end),
    .above_terminal (above_terminal)
  );
  assign finish_count = at_end;
  // once a one-shot count has completed, enables are ignored until cleared
  assign step    = enable && !(mode == CNT_ONESHOT && done);
  // wrapping or out-of-range counts both restart from the start of the current direction
  assign restart = dir == CNT_UP ? '0 : terminal;
  // next count / done / pulse by priority: clear, load, step, hold
  always_comb begin
    count_next = count_out;
    done_next  = done;
    pulse_next = 1'b0;
    if (sync_reset) begin
      count_next = '0;
      done_next  = 1'b0;
    end else if (load) begin
      count_next = load_value > terminal ? terminal : load_value;
      done_next  = 1'b0;
    end else if (step) begin
      if (at_end) begin
        pulse_next = 1'b1;
        done_next  = done || mode == CNT_ONESHOT;
        count_next = mode == CNT_ONESHOT ? count_out : restart;
      end else
        count_next = above_terminal ? restart
                   : dir == CNT_UP ? count_out + WORD_LENGTH'(1) : count_out - WORD_LENGTH'(1);
    end
  end
  // state registers; the mode register is written independently of the count priority chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out  <= '0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
      mode       <= cnt_mode_t'(ONE_SHOT_DEFAULT);
    end else begin
      count_out  <= count_next;
      done       <= done_next;
      wrap_pulse <= pulse_next;
      if (mode_we) mode <= cnt_mode_t'(one_shot_in);
    end
  end
endmodule

// File: tb/tb_programmable_updown_counter.sv
// tb_programmable_updown_counter: directed and randomized checks against a behavioural model
module tb_programmable_updown_counter;
  localparam int W = 8;
  localparam int MOD = 1 << W;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, sync_reset = 1'b0, load = 1'b0;
  logic up_down = 1'b1, mode_we = 1'b0, one_shot_in = 1'b0;
  logic [W-1:0] load_value = '0, command_length = '0, count_out;
  logic finish_count, wrap_pulse, done;
  int checks = 0, errors = 0;
  int m_count = 0, m_done = 0, m_pulse = 0, m_mode = 0;
  programmable_updown_counter #(.WORD_LENGTH(W), .ONE_SHOT_DEFAULT(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sync_reset     (sync_reset),
    .load           (load),
    .load_value     (load_value),
    .command_length (command_length),
    .up_down        (up_down),
    .mode_we        (mode_we),
    .one_shot_in    (one_shot_in),
    .count_out      (count_out),
    .finish_count   (finish_count),
    .wrap_pulse     (wrap_pulse),
    .done           (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int term_of(input int len);
    return (len + MOD - 1) % MOD;
  endfunction
  task automatic model_reset();
    m_count = 0; m_done = 0; m_pulse = 0; m_mode = 0;
  endtask
  task automatic model_step();
    int t, e;
    t = term_of(int'(command_length));
    e = up_down ? t : 0;
    m_pulse = 0;
    if (sync_reset) begin
      m_count = 0; m_done = 0;
    end else if (load) begin
      m_count = int'(load_value) < t ? int'(load_value) : t; m_done = 0;
    end else if (enable && !(m_mode == 1 && m_done == 1)) begin
      if (m_count == e) begin
        m_pulse = 1;
        if (m_mode == 1) m_done = 1;
        else m_count = up_down ? 0 : t;
      end else if (m_count > t) m_count = up_down ? 0 : t;
      else m_count = up_down ? m_count + 1 : m_count - 1;
    end
    if (mode_we) m_mode = int'(one_shot_in);
  endtask
  task automatic compare_all(input string tag);
    int e;
    e = up_down ? term_of(int'(command_length)) : 0;
    check({tag, ".count"}, int'(count_out), m_count);
    check({tag, ".pulse"}, int'(wrap_pulse), m_pulse);
    check({tag, ".done"}, int'(done), m_done);
    check({tag, ".finish"}, int'(finish_count), int'(m_count == e));
  endtask
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask
  task automatic idle();
    enable = 0; sync_reset = 0; load = 0; mode_we = 0;
  endtask
  initial begin
    #2;
    check("reset.count", int'(count_out), 0);
    check("reset.done", int'(done), 0);
    check("reset.pulse", int'(wrap_pulse), 0);
    @(negedge clk);
    reset = 1;
    model_reset();
    // up, wrap, L=5
    command_length = 5; up_down = 1; mode_we = 1; one_shot_in = 0; enable = 1;
    for (int i = 0; i < 12; i++) begin
      cycle("up_wrap");
      mode_we = 0;
    end
    // down, one-shot from load 3
    idle(); load = 1; load_value = 3; mode_we = 1; one_shot_in = 1; up_down = 0;
    cycle("load3");
    idle(); enable = 1;
    for (int i = 0; i < 6; i++) cycle("down_oneshot");
    check("oneshot.done_const", int'(done), 1);
    check("oneshot.count_const", int'(count_out), 0);
    // full range L=0 from 254, wrap mode
    idle(); load = 1; load_value = 254; command_length = 0; up_down = 1; mode_we = 1; one_shot_in = 0;
    cycle("load254");
    idle(); enable = 1;
    for (int i = 0; i < 2; i++) cycle("full_range");
    check("full_range.count_const", int'(count_out), 0);
    check("full_range.pulse_const", int'(wrap_pulse), 1);
    // length shrinks mid-count
    idle(); load = 1; load_value = 7; command_length = 10;
    cycle("load7");
    command_length = 4; load = 0; enable = 1;
    cycle("shrink");
    check("shrink.pulse_const", int'(wrap_pulse), 0);
    for (int i = 0; i < 6; i++) cycle("shrink_run");
    // simultaneous clear/load/enable, then clamped load
    idle(); sync_reset = 1; load = 1; load_value = 9; enable = 1;
    cycle("srst_load");
    idle(); load = 1; load_value = 9; command_length = 6;
    cycle("clamp");
    check("clamp.count_const", int'(count_out), 5);
    // one-shot to done at 3, then async reset mid-cycle
    idle(); mode_we = 1; one_shot_in = 1; load = 1; load_value = 0; command_length = 4; up_down = 1;
    cycle("os_setup");
    idle(); enable = 1;
    for (int i = 0; i < 5; i++) cycle("os_run");
    check("os.done_pre_reset", int'(done), 1);
    #2;
    reset = 0;
    #1;
    check("async.count", int'(count_out), 0);
    check("async.done", int'(done), 0);
    check("async.pulse", int'(wrap_pulse), 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    // mode back to wrap: counting past terminal must wrap again
    for (int i = 0; i < 6; i++) cycle("post_reset");
    // randomized phase
    for (int i = 0; i < 400; i++) begin
      sync_reset = $urandom_range(0, 29) == 0;
      load = $urandom_range(0, 11) == 0;
      enable = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      if ($urandom_range(0, 15) == 0) command_length = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, MOD - 1) : $urandom_range(0, 12));
      load_value = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, MOD - 1) : $urandom_range(0, 15));
      mode_we = $urandom_range(0, 19) == 0;
      one_shot_in = 1'($urandom_range(0, 1));
      cycle("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
